// File: rtl/dbgproto_pkg.sv
// Shared debug control byte protocol definitions.
// Both the encoder and the decoder import this package so they agree on byte values.
package dbgproto_pkg;

    localparam logic [7:0] CH_HALT  = 8'h68;
    localparam logic [7:0] CH_START = 8'h67;
    localparam logic [7:0] CH_STEP  = 8'h73;
    localparam logic [7:0] CH_CYCLE = 8'h63;
    localparam logic [7:0] CH_RESET = 8'h72;
    localparam logic [7:0] CH_PRINT = 8'h70;
    localparam logic [7:0] CH_WRITE = 8'h77;
    localparam logic [7:0] CH_COLON = 8'h3A;

    localparam int WR_FRAME_LEN = 19;

    typedef enum logic [2:0] {
        CMD_HALT  = 3'd0,
        CMD_START = 3'd1,
        CMD_STEP  = 3'd2,
        CMD_CYCLE = 3'd3,
        CMD_RESET = 3'd4,
        CMD_PRINT = 3'd5
    } cmd_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAITHI,
        ST_WAITLO
    } state_e;

    function automatic logic cmd_is_valid(input logic [2:0] code);
        return code <= 3'd5;
    endfunction

    // Codes 6 and 7 have no byte; they are dropped before reaching the line.
    function automatic logic [7:0] cmd_to_char(input logic [2:0] code);
        logic [7:0] ch;
        case (code)
            CMD_HALT:  ch = CH_HALT;
            CMD_START: ch = CH_START;
            CMD_STEP:  ch = CH_STEP;
            CMD_CYCLE: ch = CH_CYCLE;
            CMD_RESET: ch = CH_RESET;
            CMD_PRINT: ch = CH_PRINT;
            default:   ch = 8'h00;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/nibbletohex.sv
// Combinational 4-bit to lowercase ASCII hex digit converter.
module nibbletohex (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h57 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/ctltouart.sv
// Debug control command encoder: serialises commands and program writes into
// ASCII bytes and paces them through the uarttx char/txen/busy handshake.
module ctltouart
    import dbgproto_pkg::*;
#(
    parameter logic [7:0] EOL = 8'h0A
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_code,
    output logic        cmd_ready,
    input  logic        wr_valid,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic        uartbusy,
    output logic [7:0]  charout,
    output logic        uarttxen,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [2:0]  code_q, code_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  charout_q, charout_d;

    logic [63:0] addr_data;
    logic [3:0]  nib_sel;
    logic [3:0]  nibble;
    logic [7:0]  hex_char;
    logic [7:0]  frame_char;
    logic        last_byte;

    // Bytes 1..8 carry address nibbles, 10..17 data nibbles; skip the ':' slot.
    always_comb begin
        addr_data = {addr_q, data_q};
        if (idx_q < 5'd10) begin
            nib_sel = idx_q[3:0] - 4'd1;
        end else begin
            nib_sel = idx_q[3:0] - 4'd2;
        end
        nibble = addr_data[{~nib_sel, 2'b11} -: 4];
    end

    nibbletohex u_nibbletohex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        frame_char = hex_char;
        if (!is_wr_q) begin
            frame_char = cmd_to_char(code_q);
        end else begin
            case (idx_q)
                5'd0:    frame_char = CH_WRITE;
                5'd9:    frame_char = CH_COLON;
                5'd18:   frame_char = EOL;
                default: frame_char = hex_char;
            endcase
        end
        last_byte = is_wr_q ? (idx_q == 5'(WR_FRAME_LEN - 1)) : 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        code_d    = code_q;
        addr_d    = addr_q;
        data_d    = data_q;
        is_wr_d   = is_wr_q;
        charout_d = charout_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    code_d  = cmd_code;
                    is_wr_d = 1'b0;
                    idx_d   = 5'd0;
                    state_d = ST_LOAD;
                end else if (wr_valid) begin
                    addr_d  = wr_addr;
                    data_d  = wr_data;
                    is_wr_d = 1'b1;
                    idx_d   = 5'd0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!is_wr_q && !cmd_is_valid(code_q)) begin
                    state_d = ST_IDLE;
                end else begin
                    charout_d = frame_char;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAITHI;
            end
            ST_WAITHI: begin
                if (uartbusy) begin
                    state_d = ST_WAITLO;
                end
            end
            ST_WAITLO: begin
                if (!uartbusy) begin
                    if (last_byte) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 5'd0;
            code_q    <= 3'd0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            is_wr_q   <= 1'b0;
            charout_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            is_wr_q   <= is_wr_d;
            charout_q <= charout_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign uarttxen  = (state_q == ST_SEND);
    assign charout   = charout_q;

endmodule

// File: tb/tb_ctltouart.sv
// Self-checking bench for ctltouart with a bus-functional uarttx model
// and a byte scoreboard fed at stimulus time, drained on each strobe.
module tb_ctltouart;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic        cmd_ready;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        uartbusy;
    logic [7:0]  charout;
    logic        uarttxen;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int strobe_cnt = 0;
    int busy_len = 520;
    int busy_cnt;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ctltouart #(.EOL(8'h0A)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .uartbusy  (uartbusy),
        .charout   (charout),
        .uarttxen  (uarttxen),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] hex_ch(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
    endfunction

    function automatic void push_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back(8'h77);
        for (int i = 7; i >= 0; i--) exp_q.push_back(hex_ch(a[i*4 +: 4]));
        exp_q.push_back(8'h3A);
        for (int i = 7; i >= 0; i--) exp_q.push_back(hex_ch(d[i*4 +: 4]));
        exp_q.push_back(8'h0A);
    endfunction

    // uarttx model: busy rises the cycle after txen and stays up busy_len cycles.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            uartbusy <= 1'b0;
            busy_cnt <= 0;
        end else if (uartbusy) begin
            if (busy_cnt <= 1) uartbusy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (uarttxen) begin
            uartbusy <= 1'b1;
            busy_cnt <= busy_len;
        end
    end

    always @(negedge clk) begin
        if (n_rst && uarttxen) begin
            strobe_cnt++;
            checkOutput("strobe_while_busy", {31'h0, uartbusy}, 32'h0);
            checkOutput("sb_has_entry", {31'h0, exp_q.size() > 0}, 32'h1);
            if (exp_q.size() > 0) checkOutput("byte", {24'h0, charout}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cv, input logic [2:0] code, input logic wv,
                                 input logic [31:0] a, input logic [31:0] d);
        cmd_valid = cv;
        cmd_code  = code;
        wr_valid  = wv;
        wr_addr   = a;
        wr_data   = d;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        checkOutput({tag, "_done"}, {31'h0, busy}, 32'h0);
        checkOutput({tag, "_sb_empty"}, exp_q.size(), 32'h0);
    endtask

    task automatic wait_ubusy(input logic level, input int max, input string tag);
        int n = 0;
        while (uartbusy !== level && n < max) begin
            step();
            n++;
        end
        checkOutput(tag, {31'h0, uartbusy}, {31'h0, level});
    endtask

    initial begin
        int s0;
        int s1;
        int n;
        n_rst = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        checkOutput("rst_charout", {24'h0, charout}, 32'h0);
        checkOutput("rst_txen", {31'h0, uarttxen}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        checkOutput("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
        n_rst = 1'b1;
        step();

        $display("[TB] single command");
        s0 = strobe_cnt;
        exp_q.push_back(8'h73);
        applyStimulus(1'b1, 3'd2, 1'b0, 32'h0, 32'h0);
        step();
        cmd_valid = 1'b0;
        checkOutput("cmd_load_busy", {31'h0, busy}, 32'h1);
        checkOutput("cmd_load_ready", {31'h0, cmd_ready}, 32'h0);
        checkOutput("cmd_load_txen", {31'h0, uarttxen}, 32'h0);
        step();
        checkOutput("cmd_send_txen", {31'h0, uarttxen}, 32'h1);
        checkOutput("cmd_send_char", {24'h0, charout}, 32'h73);
        wait_ubusy(1'b1, 10, "cmd_ubusy_rise");
        wait_ubusy(1'b0, 600, "cmd_ubusy_fall");
        checkOutput("cmd_busy_lag", {31'h0, busy}, 32'h1);
        step();
        checkOutput("cmd_busy_fall", {31'h0, busy}, 32'h0);
        checkOutput("cmd_ready_back", {31'h0, cmd_ready}, 32'h1);
        checkOutput("cmd_strobes", strobe_cnt - s0, 32'd1);

        $display("[TB] write frame");
        busy_len = 16;
        s0 = strobe_cnt;
        push_write(32'h0000_0010, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 3'd0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        step();
        wr_valid = 1'b0;
        wait_idle("write", 19 * 40);
        checkOutput("write_strobes", strobe_cnt - s0, 32'd19);

        $display("[TB] simultaneous requests");
        busy_len = 6;
        s0 = strobe_cnt;
        exp_q.push_back(8'h68);
        push_write(32'hA5A5_0F0F, 32'h0123_4567);
        applyStimulus(1'b1, 3'd0, 1'b1, 32'hA5A5_0F0F, 32'h0123_4567);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!wr_ready && n < 200) begin
            step();
            n++;
        end
        checkOutput("sim_wr_ready", {31'h0, wr_ready}, 32'h1);
        checkOutput("sim_after_h", strobe_cnt - s0, 32'd1);
        checkOutput("sim_pending", exp_q.size(), 32'd19);
        step();
        wr_valid = 1'b0;
        checkOutput("sim_wr_taken", {31'h0, wr_ready}, 32'h0);
        wait_idle("sim", 19 * 30);
        checkOutput("sim_strobes", strobe_cnt - s0, 32'd20);

        $display("[TB] invalid code");
        s0 = strobe_cnt;
        applyStimulus(1'b1, 3'd7, 1'b0, 32'h0, 32'h0);
        step();
        cmd_valid = 1'b0;
        checkOutput("inv_busy", {31'h0, busy}, 32'h1);
        checkOutput("inv_ready", {31'h0, cmd_ready}, 32'h0);
        step();
        checkOutput("inv_busy_end", {31'h0, busy}, 32'h0);
        checkOutput("inv_ready_back", {31'h0, cmd_ready}, 32'h1);
        repeat (5) step();
        checkOutput("inv_strobes", strobe_cnt - s0, 32'd0);

        $display("[TB] reset mid-frame");
        busy_len = 10;
        push_write(32'h1234_5678, 32'h9ABC_DEF0);
        applyStimulus(1'b0, 3'd0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        step();
        wr_valid = 1'b0;
        n = 0;
        while (!(uarttxen && charout == 8'h3A) && n < 1000) begin
            step();
            n++;
        end
        checkOutput("rmf_at_byte9", {24'h0, charout}, 32'h3A);
        n_rst = 1'b0;
        #1;
        checkOutput("rmf_txen", {31'h0, uarttxen}, 32'h0);
        checkOutput("rmf_busy", {31'h0, busy}, 32'h0);
        checkOutput("rmf_ready", {31'h0, cmd_ready}, 32'h1);
        exp_q.delete();
        step();
        step();
        n_rst = 1'b1;
        step();
        s0 = strobe_cnt;
        push_write(32'hCAFE_0001, 32'h0000_00FF);
        applyStimulus(1'b0, 3'd0, 1'b1, 32'hCAFE_0001, 32'h0000_00FF);
        step();
        wr_valid = 1'b0;
        step();
        checkOutput("rmf_restart_txen", {31'h0, uarttxen}, 32'h1);
        checkOutput("rmf_restart_w", {24'h0, charout}, 32'h77);
        wait_idle("rmf", 19 * 30);
        checkOutput("rmf_strobes", strobe_cnt - s0, 32'd19);

        $display("[TB] stalled transmitter");
        busy_len = 5000;
        s0 = strobe_cnt;
        exp_q.push_back(8'h72);
        exp_q.push_back(8'h70);
        applyStimulus(1'b1, 3'd4, 1'b0, 32'h0, 32'h0);
        step();
        cmd_code = 3'd5;
        wait_ubusy(1'b1, 10, "stall_rise");
        s1 = strobe_cnt;
        wait_ubusy(1'b0, 5100, "stall_fall");
        busy_len = 12;
        checkOutput("stall_no_strobe", strobe_cnt - s1, 32'd0);
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        checkOutput("stall_ready", {31'h0, cmd_ready}, 32'h1);
        step();
        cmd_valid = 1'b0;
        wait_idle("stall", 200);
        checkOutput("stall_strobes", strobe_cnt - s0, 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
